// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
// Covers the ALU encoding, the ALU operation classes, opcodes, functs and FSM states.
package mips_pkg;

  typedef enum logic [5:0] {
    ALU_AND = 6'h00,
    ALU_OR  = 6'h01,
    ALU_ADD = 6'h02,
    ALU_SUB = 6'h06,
    ALU_SLT = 6'h07
  } alu_ctrl_t;

  // operation class requested by the FSM; AOP_FUNCT defers to the R-type funct field
  typedef enum logic [1:0] {
    AOP_AND,
    AOP_ADD,
    AOP_SUB,
    AOP_FUNCT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC,
    S_ALU_WB,
    S_BRANCH,
    S_ADDI_EX,
    S_ADDI_WB,
    S_JUMP
  } ctrl_state_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the FSM's ALU operation class plus the R-type funct field onto the ALU encoding.
// An unsupported funct selects AND and raises the illegal flag.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output alu_ctrl_t  alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_AND;
    illegal     = 1'b0;
    case (alu_op)
      AOP_ADD: alu_control = ALU_ADD;
      AOP_SUB: alu_control = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Outputs are decoded from the state register.
// pc_en, ir_write and the branch enable additionally depend on same-cycle inputs.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int ALU_CTRL_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  alu_zero,
  input  logic                  mem_ready,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_src,
  output logic                  pc_en,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  illegal_op
);

  ctrl_state_t state;
  alu_op_t     alu_op;
  alu_ctrl_t   alu_dec;
  logic        funct_illegal;

  mips_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_dec),
    .illegal     (funct_illegal)
  );

  assign alu_control = ALU_CTRL_W'(alu_dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (run) state <= S_FETCH;
        S_FETCH:   if (mem_ready) state <= run ? S_DECODE : S_IDLE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEM_ADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDI_EX;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEM_ADR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:  if (mem_ready) state <= S_MEM_WB;
        S_MEM_WR:  if (mem_ready) state <= S_FETCH;
        S_EXEC:    state <= funct_illegal ? S_FETCH : S_ALU_WB;
        S_ADDI_EX: state <= S_ADDI_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: state <= S_FETCH;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_op     = AOP_AND;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_src     = 2'd0;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = AOP_ADD;
        pc_en     = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'd3;
        alu_op     = AOP_ADD;
        illegal_op = !is_known_op(opcode);
      end
      S_MEM_ADR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = AOP_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = AOP_FUNCT;
        illegal_op = funct_illegal;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_SUB;
        pc_src    = 2'd1;
        pc_en     = alu_zero;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'd2;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
